// File: rtl/btb_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// btb_ctrl
// Write-port controller for a branch target buffer shared by two threads.
//
// After reset, and on every flush request, the whole array is invalidated by
// sweeping one entry per cycle. While idle, resolved branches from the two
// threads are arbitrated round-robin. The winner is registered and written to
// the array on the following cycle.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   upd_valid    per-thread update request (bit t = thread t)
//   upd_ready    per-thread update accept (one-hot or zero)
//   upd_pc       resolved branch PC, {t1[63:0], t0[63:0]}
//   upd_target   resolved target, {t1, t0}
//   upd_type     branch type, {t1[1:0], t0[1:0]}
//   flush_req    one-cycle pulse: invalidate all entries
//   flush_busy   invalidate sweep in progress
//   lookup_stall predictor lookups must be ignored this cycle
//   wr_en        array write strobe
//   wr_index     array write index
//   wr_valid     valid bit written
//   wr_tag       tag written
//   wr_target    target written
//   wr_type      branch type written
//   wr_thread    thread id written
//   upd_cnt      saturating count of committed update writes
// -----------------------------------------------------------------------------
module btb_ctrl #(
  parameter int ENTRIES = 1024,
  parameter int IDX_W   = 10,
  parameter int TAG_W   = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         upd_valid,
  output logic [1:0]         upd_ready,
  input  logic [127:0]       upd_pc,
  input  logic [127:0]       upd_target,
  input  logic [3:0]         upd_type,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               lookup_stall,
  output logic               wr_en,
  output logic [IDX_W-1:0]   wr_index,
  output logic               wr_valid,
  output logic [TAG_W-1:0]   wr_tag,
  output logic [63:0]        wr_target,
  output logic [1:0]         wr_type,
  output logic               wr_thread,
  output logic [15:0]        upd_cnt
);

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Saturating increment for the update counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    logic [15:0] res;
    if (val == 16'hFFFF) begin
      res = val;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

  // Array index taken from the word-aligned PC bits just above the byte offset.
  function automatic logic [IDX_W-1:0] pc_index(input logic [63:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  // Tag taken from the top of the PC.
  function automatic logic [TAG_W-1:0] pc_tag(input logic [63:0] pc);
    return pc[63 -: TAG_W];
  endfunction

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  // State
  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   sweep_idx_r;
  logic [IDX_W-1:0]   sweep_idx_nxt_s;
  logic               sweep_fire_s;
  logic               rr_ptr_r;

  // Arbitration
  logic [1:0]         grant_s;
  logic [63:0]        sel_pc_s;
  logic [63:0]        sel_target_s;
  logic [1:0]         sel_type_s;

  // Pending update write
  logic               pend_valid_r;
  logic [IDX_W-1:0]   pend_index_r;
  logic [TAG_W-1:0]   pend_tag_r;
  logic [63:0]        pend_target_r;
  logic [1:0]         pend_type_r;
  logic               pend_thread_r;

  // Write port
  logic               wr_en_s;
  logic [IDX_W-1:0]   wr_index_s;
  logic               wr_valid_s;
  logic [TAG_W-1:0]   wr_tag_s;
  logic [63:0]        wr_target_s;
  logic [1:0]         wr_type_s;
  logic               wr_thread_s;
  logic               upd_write_s;

  logic [15:0]        upd_cnt_r;

  // Only some PC bits feed the array; the rest are intentionally dropped.
  logic               unused_pc_s;
  assign unused_pc_s = ^upd_pc;

  // A registered update owns the array port; the sweep waits a cycle behind it.
  assign sweep_fire_s = (state_r == ST_SWEEP) && !pend_valid_r;

  // Round-robin grant; nothing is granted while sweeping or while a flush is requested.
  always_comb begin
    grant_s = 2'b00;
    if ((state_r == ST_IDLE) && !flush_req) begin
      case (upd_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = rr_ptr_r ? 2'b10 : 2'b01;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  // Select the granted thread's update fields.
  always_comb begin
    sel_pc_s     = upd_pc[63:0];
    sel_target_s = upd_target[63:0];
    sel_type_s   = upd_type[1:0];
    if (grant_s[1]) begin
      sel_pc_s     = upd_pc[127:64];
      sel_target_s = upd_target[127:64];
      sel_type_s   = upd_type[3:2];
    end else begin
      sel_pc_s     = upd_pc[63:0];
      sel_target_s = upd_target[63:0];
      sel_type_s   = upd_type[1:0];
    end
  end

  // Next-state logic for the sweep FSM.
  always_comb begin
    state_nxt_s     = state_r;
    sweep_idx_nxt_s = sweep_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (flush_req) begin
          state_nxt_s     = ST_SWEEP;
          sweep_idx_nxt_s = {IDX_W{1'b0}};
        end else begin
          state_nxt_s     = ST_IDLE;
          sweep_idx_nxt_s = sweep_idx_r;
        end
      end
      ST_SWEEP: begin
        if (flush_req) begin
          // A new flush restarts the sweep from the bottom.
          state_nxt_s     = ST_SWEEP;
          sweep_idx_nxt_s = {IDX_W{1'b0}};
        end else if (sweep_fire_s) begin
          if (sweep_idx_r == LAST_IDX) begin
            state_nxt_s     = ST_IDLE;
            sweep_idx_nxt_s = {IDX_W{1'b0}};
          end else begin
            state_nxt_s     = ST_SWEEP;
            sweep_idx_nxt_s = sweep_idx_r + IDX_W'(1'b1);
          end
        end else begin
          state_nxt_s     = ST_SWEEP;
          sweep_idx_nxt_s = sweep_idx_r;
        end
      end
      default: begin
        state_nxt_s     = ST_SWEEP;
        sweep_idx_nxt_s = {IDX_W{1'b0}};
      end
    endcase
  end

  // Sweep FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_SWEEP;
      sweep_idx_r <= {IDX_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      sweep_idx_r <= sweep_idx_nxt_s;
    end
  end

  // Round-robin pointer and the pending-update register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r      <= 1'b0;
      pend_valid_r  <= 1'b0;
      pend_index_r  <= {IDX_W{1'b0}};
      pend_tag_r    <= {TAG_W{1'b0}};
      pend_target_r <= 64'h0;
      pend_type_r   <= 2'b00;
      pend_thread_r <= 1'b0;
    end else begin
      pend_valid_r <= |grant_s;
      if (|grant_s) begin
        // The thread just served drops to lower priority.
        rr_ptr_r      <= ~grant_s[1];
        pend_index_r  <= pc_index(sel_pc_s);
        pend_tag_r    <= pc_tag(sel_pc_s);
        pend_target_r <= sel_target_s;
        pend_type_r   <= sel_type_s;
        pend_thread_r <= grant_s[1];
      end else begin
        rr_ptr_r      <= rr_ptr_r;
        pend_index_r  <= pend_index_r;
        pend_tag_r    <= pend_tag_r;
        pend_target_r <= pend_target_r;
        pend_type_r   <= pend_type_r;
        pend_thread_r <= pend_thread_r;
      end
    end
  end

  // Array write port: pending update first, then sweep, and silent while in reset.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_index_s  = {IDX_W{1'b0}};
    wr_valid_s  = 1'b0;
    wr_tag_s    = {TAG_W{1'b0}};
    wr_target_s = 64'h0;
    wr_type_s   = 2'b00;
    wr_thread_s = 1'b0;
    if (!rst_n) begin
      wr_en_s = 1'b0;
    end else if (pend_valid_r) begin
      wr_en_s     = 1'b1;
      wr_index_s  = pend_index_r;
      wr_valid_s  = 1'b1;
      wr_tag_s    = pend_tag_r;
      wr_target_s = pend_target_r;
      wr_type_s   = pend_type_r;
      wr_thread_s = pend_thread_r;
    end else if (sweep_fire_s) begin
      wr_en_s    = 1'b1;
      wr_index_s = sweep_idx_r;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  assign upd_write_s = wr_en_s & wr_valid_s;

  // Committed-update counter; invalidating sweep writes are not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_cnt_r <= 16'h0000;
    end else if (upd_write_s) begin
      upd_cnt_r <= sat_inc16(upd_cnt_r);
    end else begin
      upd_cnt_r <= upd_cnt_r;
    end
  end

  assign upd_ready    = grant_s;
  assign flush_busy   = (state_r == ST_SWEEP);
  assign lookup_stall = (state_r == ST_SWEEP);
  assign wr_en        = wr_en_s;
  assign wr_index     = wr_index_s;
  assign wr_valid     = wr_valid_s;
  assign wr_tag       = wr_tag_s;
  assign wr_target    = wr_target_s;
  assign wr_type      = wr_type_s;
  assign wr_thread    = wr_thread_s;
  assign upd_cnt      = upd_cnt_r;

endmodule

// File: tb/tb_btb_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for btb_ctrl: stimulus pushes expected array writes into a
// queue, a negedge monitor pops one entry per observed write and compares.
module tb_btb_ctrl;

  localparam int ENTRIES = 1024;
  localparam int IDX_W   = 10;
  localparam int TAG_W   = 48;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         upd_valid;
  logic [1:0]         upd_ready;
  logic [127:0]       upd_pc;
  logic [127:0]       upd_target;
  logic [3:0]         upd_type;
  logic               flush_req;
  logic               flush_busy;
  logic               lookup_stall;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_index;
  logic               wr_valid;
  logic [TAG_W-1:0]   wr_tag;
  logic [63:0]        wr_target;
  logic [1:0]         wr_type;
  logic               wr_thread;
  logic [15:0]        upd_cnt;

  btb_ctrl #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_type(upd_type),
    .flush_req(flush_req), .flush_busy(flush_busy), .lookup_stall(lookup_stall),
    .wr_en(wr_en), .wr_index(wr_index), .wr_valid(wr_valid), .wr_tag(wr_tag),
    .wr_target(wr_target), .wr_type(wr_type), .wr_thread(wr_thread),
    .upd_cnt(upd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             v;
    logic [TAG_W-1:0] tag;
    logic [63:0]      tgt;
    logic [1:0]       ty;
    logic             th;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_act;
  wr_t mon_exp;
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic wr_t mk_upd(input logic [9:0] idx, input logic [47:0] tag,
                                 input logic [63:0] tgt, input logic [1:0] ty, input logic th);
    wr_t w;
    w.idx = idx; w.v = 1'b1; w.tag = tag; w.tgt = tgt; w.ty = ty; w.th = th;
    return w;
  endfunction

  function automatic wr_t mk_sweep(input int i);
    wr_t w;
    w = '0;
    w.idx = IDX_W'(i);
    return w;
  endfunction

  task automatic push_sweep(input int upto);
    for (int i = 0; i <= upto; i++) exp_q.push_back(mk_sweep(i));
  endtask

  // Monitor: every observed write must match the next expected one.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      mon_act = {wr_index, wr_valid, wr_tag, wr_target, wr_type, wr_thread};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got %0h, required no write", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("wr_fields", mon_act, mon_exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Runs a full sweep window, checking busy/stall/ready each cycle, then IDLE.
  task automatic watch_sweep(input string tag);
    for (int c = 1; c <= ENTRIES; c++) begin
      @(negedge clk);
      check({tag, "_busy"}, flush_busy, 1'b1);
      check({tag, "_stall"}, lookup_stall, 1'b1);
      check({tag, "_ready"}, upd_ready, 2'b00);
      if (c == 8) upd_valid = 2'b00;
    end
    @(negedge clk);
    check({tag, "_busy_end"}, flush_busy, 1'b0);
    check({tag, "_idle_wr_en"}, wr_en, 1'b0);
  endtask

  wr_t t0_e, t1_e;

  initial begin
    rst_n = 1'b0; upd_valid = 2'b00; upd_pc = '0; upd_target = '0;
    upd_type = 4'b0000; flush_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_cnt", upd_cnt, 16'h0000);
    check("rst_busy", flush_busy, 1'b1);

    // Reset release: full invalidate sweep, requests ignored.
    @(posedge clk); #1;
    rst_n = 1'b1; upd_valid = 2'b11;
    push_sweep(ENTRIES - 1);
    watch_sweep("init");
    check("init_cnt", upd_cnt, 16'h0000);

    // Single t0 update with hand-decoded index/tag.
    @(posedge clk); #1;
    upd_valid = 2'b01;
    upd_pc = {64'h0, 64'h0000_ABCD_0000_1F04};
    upd_target = {64'h0, 64'h1234_5678_9ABC_DEF0};
    upd_type = 4'b0010;
    exp_q.push_back(mk_upd(10'h3C1, 48'h0000_ABCD_0000, 64'h1234_5678_9ABC_DEF0, 2'b10, 1'b0));
    @(negedge clk); check("t0_ready", upd_ready, 2'b01);
    @(posedge clk); #1; upd_valid = 2'b00;
    @(negedge clk); check("t0_lat_wr_en", wr_en, 1'b1); check("t0_cnt_before", upd_cnt, 16'h0000);
    @(posedge clk); #1;
    @(negedge clk); check("idle_no_wr", wr_en, 1'b0); check("t0_cnt", upd_cnt, 16'h0001);

    // Single t1 update (also returns rr_ptr to 0).
    @(posedge clk); #1;
    upd_valid = 2'b10;
    upd_pc = {64'hFFFF_0000_1234_5678, 64'h0};
    upd_target = {64'h0BAD_F00D_0000_0040, 64'h0};
    upd_type = 4'b0100;
    exp_q.push_back(mk_upd(10'h19E, 48'hFFFF_0000_1234, 64'h0BAD_F00D_0000_0040, 2'b01, 1'b1));
    @(negedge clk); check("t1_ready", upd_ready, 2'b10);
    @(posedge clk); #1; upd_valid = 2'b00;

    // Both threads valid for 4 cycles: alternate t0,t1,t0,t1.
    upd_pc = {64'h0000_0000_0001_0020, 64'h0000_0000_0000_0010};
    upd_target = {64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};
    upd_type = 4'b1101;
    t0_e = mk_upd(10'h004, 48'h0, 64'hAAAA_AAAA_AAAA_AAAA, 2'b01, 1'b0);
    t1_e = mk_upd(10'h008, 48'h1, 64'h5555_5555_5555_5555, 2'b11, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      upd_valid = 2'b11;
      exp_q.push_back((k % 2 == 0) ? t0_e : t1_e);
      @(negedge clk);
      check("rr_ready", upd_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) check("rr_wr_thread", wr_thread, ((k - 1) % 2 == 1) ? 1'b1 : 1'b0);
    end
    @(posedge clk); #1; upd_valid = 2'b00;
    @(negedge clk); check("rr_last_wr_thread", wr_thread, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); check("rr_cnt", upd_cnt, 16'h0006);

    // Update at N, flush at N+1: update write wins, sweep at N+2.
    @(posedge clk); #1;
    upd_valid = 2'b01;
    upd_pc = {64'h0, 64'h0000_0000_0000_0FFC};
    upd_target = {64'h0, 64'hDEAD_BEEF_CAFE_0000};
    upd_type = 4'b0011;
    exp_q.push_back(mk_upd(10'h3FF, 48'h0, 64'hDEAD_BEEF_CAFE_0000, 2'b11, 1'b0));
    @(negedge clk); check("col_grant", upd_ready, 2'b01);
    @(posedge clk); #1;
    flush_req = 1'b1;
    push_sweep(500);
    push_sweep(ENTRIES - 1);
    @(negedge clk);
    check("col_ready", upd_ready, 2'b00);
    check("col_busy", flush_busy, 1'b0);
    check("col_wr_valid", wr_valid, 1'b1);
    @(posedge clk); #1; flush_req = 1'b0;
    @(negedge clk);
    check("col_sweep_busy", flush_busy, 1'b1);
    check("col_sweep_ready", upd_ready, 2'b00);
    check("col_sweep_idx", wr_index, 10'd0);
    check("col_sweep_valid", wr_valid, 1'b0);
    @(posedge clk); #1; upd_valid = 2'b00;

    // Flush again while the sweep is writing index 500.
    repeat (499) @(posedge clk);
    #1; flush_req = 1'b1;
    @(negedge clk); check("restart_at_500", wr_index, 10'd500);
    @(posedge clk); #1; flush_req = 1'b0;
    watch_sweep("restart");
    check("restart_cnt", upd_cnt, 16'h0007);

    // Reset with an update pending: the write is dropped, state reinitialised.
    @(posedge clk); #1;
    upd_valid = 2'b01;
    upd_pc = {64'h0, 64'h0000_0000_0000_0100};
    @(negedge clk); check("pend_grant", upd_ready, 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b0; upd_valid = 2'b00;
    exp_q.delete();
    @(negedge clk); check("rst_pend_wr_en", wr_en, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst2_cnt", upd_cnt, 16'h0000);
    check("rst2_busy", flush_busy, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_sweep(ENTRIES - 1);

    // Reset again mid-sweep: progress discarded, sweep restarts at index 0.
    repeat (99) @(posedge clk);
    #1; rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk); check("rst_mid_wr_en", wr_en, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_sweep(ENTRIES - 1);
    watch_sweep("rst_mid");

    // Saturation: run the counter up to 16'hFFFC with back-to-back updates.
    upd_pc = {64'h0000_0000_0001_0020, 64'h0000_0000_0000_0010};
    upd_target = {64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};
    upd_type = 4'b1101;
    for (int i = 0; i < 65532; i++) begin
      @(posedge clk); #1;
      upd_valid = 2'b11;
      exp_q.push_back((i % 2 == 0) ? t0_e : t1_e);
      if (i == 0) begin
        @(negedge clk); check("rr_after_reset", upd_ready, 2'b01);
      end
    end
    @(posedge clk); #1; upd_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk); check("cnt_fffc", upd_cnt, 16'hFFFC);

    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; upd_valid = 2'b01; exp_q.push_back(t0_e);
    end
    @(posedge clk); #1; upd_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk); check("cnt_fffe", upd_cnt, 16'hFFFE);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; upd_valid = 2'b01; exp_q.push_back(t0_e);
    end
    @(posedge clk); #1; upd_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk); check("cnt_saturated", upd_cnt, 16'hFFFF);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
